// File: rtl/bus_link_pkg.sv
//--------------------------------------------------------------------
// Module  : bus_link_pkg
// Brief   : Shared types and constants for the serial bus link target
// Rev     : 1.0  initial release
//--------------------------------------------------------------------
`default_nettype none

package bus_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_MEM   = 3'd3,
        ST_RDATA = 3'd4
    } link_state_t;

    localparam int   LNK_BYTES = 4;
    localparam int   LNK_W     = 8;
    localparam logic RW_WRITE  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bus_link_target_shifter.sv
//--------------------------------------------------------------------
// Module  : word_byte_shifter
// Brief   : Word register with parallel load and LSB-first byte shift
// Rev     : 1.0  initial release
//--------------------------------------------------------------------
`default_nettype none

module word_byte_shifter #(
    parameter int BYTES  = 4,
    parameter int BYTE_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [BYTES*BYTE_W-1:0]   load_word,
    input  logic                      shift,
    input  logic [BYTE_W-1:0]         din,
    output logic [BYTES*BYTE_W-1:0]   word
);

    localparam int WORD_W = BYTES * BYTE_W;

    logic [WORD_W-1:0] r_word;

    // Shifting right with the new byte entering at the top assembles an
    // LSB-first byte stream and also presents the next byte to send at [BYTE_W-1:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
        end else if (load) begin
            r_word <= load_word;
        end else if (shift) begin
            r_word <= {din, r_word[WORD_W-1:BYTE_W]};
        end
    end

    assign word = r_word;

endmodule

`default_nettype wire

// File: rtl/bus_link_target.sv
//--------------------------------------------------------------------
// Module  : bus_link_target
// Brief   : Serial bus link endpoint issuing one memory access per frame
// Rev     : 1.0  initial release
//--------------------------------------------------------------------
`default_nettype none

module bus_link_target
    import bus_link_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lnk_sync,
    input  logic              lnk_rw,
    input  logic [7:0]        lnk_din,
    output logic [7:0]        lnk_dout,
    output logic              lnk_oe,
    output logic              lnk_busy,
    output logic              err_abort,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int WORD_W = LNK_BYTES * LNK_W;

    link_state_t       r_state;
    link_state_t       w_next_state;
    logic [1:0]        r_idx;
    logic [1:0]        w_next_idx;
    logic              w_sync_start;
    logic              w_abort;
    logic              w_last;
    logic              w_addr_shift;
    logic              w_data_shift;
    logic              w_data_load;
    logic [WORD_W-1:0] w_addr_word;
    logic [WORD_W-1:0] w_data_word;
    logic [LNK_W-1:0]  w_next_dout;

    logic              r_we;
    logic              r_mem_req;
    logic              r_busy;
    logic              r_oe;
    logic              r_err;
    logic [LNK_W-1:0]  r_dout;

    // A sync is honoured anywhere except while an access is in flight.
    assign w_sync_start = lnk_sync && (r_state != ST_MEM);
    assign w_abort      = lnk_sync && ((r_state == ST_ADDR) ||
                                       (r_state == ST_WDATA) ||
                                       (r_state == ST_RDATA));
    assign w_last       = (r_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_addr_shift = 1'b0;
        w_data_shift = 1'b0;
        w_data_load  = 1'b0;
        if (w_sync_start) begin
            w_next_state = ST_ADDR;
            w_next_idx   = 2'd1;
            w_addr_shift = 1'b1;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    w_addr_shift = 1'b1;
                    w_next_idx   = r_idx + 2'd1;
                    if (w_last) begin
                        w_next_idx   = 2'd0;
                        w_next_state = (r_we == RW_WRITE) ? ST_WDATA : ST_MEM;
                    end
                end
                ST_WDATA: begin
                    w_data_shift = 1'b1;
                    w_next_idx   = r_idx + 2'd1;
                    if (w_last) begin
                        w_next_idx   = 2'd0;
                        w_next_state = ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (r_we == RW_WRITE) begin
                            w_next_state = ST_IDLE;
                        end else begin
                            w_data_load  = 1'b1;
                            w_next_state = ST_RDATA;
                            w_next_idx   = 2'd0;
                        end
                    end
                end
                ST_RDATA: begin
                    w_data_shift = 1'b1;
                    w_next_idx   = r_idx + 2'd1;
                    if (w_last) begin
                        w_next_idx   = 2'd0;
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_idx   = 2'd0;
                end
            endcase
        end
    end

    word_byte_shifter #(
        .BYTES  (LNK_BYTES),
        .BYTE_W (LNK_W)
    ) u_addr_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_word ('0),
        .shift     (w_addr_shift),
        .din       (lnk_din),
        .word      (w_addr_word)
    );

    // Holds write data on the way in and read data on the way out.
    word_byte_shifter #(
        .BYTES  (LNK_BYTES),
        .BYTE_W (LNK_W)
    ) u_data_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_data_load),
        .load_word (mem_rdata),
        .shift     (w_data_shift),
        .din       (lnk_din),
        .word      (w_data_word)
    );

    always_comb begin
        w_next_dout = '0;
        if (w_data_load) begin
            w_next_dout = mem_rdata[LNK_W-1:0];
        end else if ((r_state == ST_RDATA) && (w_next_state == ST_RDATA)) begin
            w_next_dout = w_data_word[2*LNK_W-1:LNK_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_oe      <= 1'b0;
            r_err     <= 1'b0;
            r_dout    <= '0;
        end else begin
            if (w_sync_start) begin
                r_we <= lnk_rw;
            end
            r_mem_req <= (w_next_state == ST_MEM);
            r_busy    <= (w_next_state == ST_MEM);
            r_oe      <= (w_next_state == ST_RDATA);
            r_err     <= w_abort;
            r_dout    <= w_next_dout;
        end
    end

    assign lnk_dout  = r_dout;
    assign lnk_oe    = r_oe;
    assign lnk_busy  = r_busy;
    assign err_abort = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_we;
    assign mem_addr  = w_addr_word[ADDR_W-1:0];
    assign mem_wdata = w_data_word;

endmodule

`default_nettype wire

// File: tb/tb_bus_link_target.sv
//--------------------------------------------------------------------
// Module  : tb_bus_link_target
// Brief   : Directed self-checking bench for bus_link_target
// Rev     : 1.0  initial release
//--------------------------------------------------------------------
`default_nettype none

module tb_bus_link_target;

    logic        clk;
    logic        rst_n;
    logic        lnk_sync;
    logic        lnk_rw;
    logic [7:0]  lnk_din;
    logic [7:0]  lnk_dout;
    logic        lnk_oe;
    logic        lnk_busy;
    logic        err_abort;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    int          req_cyc = 0;
    int          acc_cnt = 0;
    int          abort_cnt = 0;
    logic [31:0] acc_addr = '0;
    logic [31:0] acc_wdata = '0;
    logic        acc_we = 1'b0;

    bus_link_target #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lnk_sync  (lnk_sync),
        .lnk_rw    (lnk_rw),
        .lnk_din   (lnk_din),
        .lnk_dout  (lnk_dout),
        .lnk_oe    (lnk_oe),
        .lnk_busy  (lnk_busy),
        .err_abort (err_abort),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side observer: completed accesses, request cycles, abort pulses.
    always @(posedge clk) begin
        if (mem_req) begin
            req_cyc <= req_cyc + 1;
            if (mem_ack) begin
                acc_cnt   <= acc_cnt + 1;
                acc_addr  <= mem_addr;
                acc_wdata <= mem_wdata;
                acc_we    <= mem_we;
            end
        end
        if (err_abort) abort_cnt <= abort_cnt + 1;
    end

    // Inputs applied at the falling edge stand for the current cycle; the
    // call returns at the next falling edge, i.e. one cycle later.
    task automatic drive(input logic s, input logic rw, input logic [7:0] d,
                         input logic a, input logic [31:0] rd);
        lnk_sync  = s;
        lnk_rw    = rw;
        lnk_din   = d;
        mem_ack   = a;
        mem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lnk_sync = 1'b0; lnk_rw = 1'b0; lnk_din = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (lnk_dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h expected 00", lnk_dout); end
        checks++; if (lnk_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b expected 0", lnk_oe); end
        checks++; if (lnk_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", lnk_busy); end
        checks++; if (err_abort !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_abort); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", mem_wdata); end
        rst_n = 1'b1;
        drive(0, 0, 8'h00, 0, '0);
    endtask

    task automatic test_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
        int base_acc = acc_cnt;
        int base_req = req_cyc;
        logic [63:0] frame = {data, addr};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL %s_early_req c%0d: got %b expected 0", tag, i, mem_req); end
            end
            drive(i == 0, 1'b1, frame[8*i +: 8], 0, '0);
        end
        // cycle 8
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL %s_req: got %b expected 1", tag, mem_req); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL %s_we: got %b expected 1", tag, mem_we); end
        checks++; if (mem_addr !== addr) begin errors++; $display("FAIL %s_addr: got %h expected %h", tag, mem_addr, addr); end
        checks++; if (mem_wdata !== data) begin errors++; $display("FAIL %s_wdata: got %h expected %h", tag, mem_wdata, data); end
        checks++; if (lnk_busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b expected 1", tag, lnk_busy); end
        drive(0, 0, 8'hFF, 1, 32'h5A5A5A5A);
        // cycle 9: back in IDLE
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL %s_req_drop: got %b expected 0", tag, mem_req); end
        checks++; if (lnk_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_drop: got %b expected 0", tag, lnk_busy); end
        checks++; if (acc_cnt - base_acc !== 1) begin errors++; $display("FAIL %s_acc_cnt: got %0d expected 1", tag, acc_cnt - base_acc); end
        checks++; if (req_cyc - base_req !== 1) begin errors++; $display("FAIL %s_req_cycles: got %0d expected 1", tag, req_cyc - base_req); end
    endtask

    // Starts in IDLE straight after a write, exercising back-to-back frames.
    task automatic test_read();
        logic [31:0] rd = 32'hCAFEF00D;
        logic [31:0] addr = 32'h00000010;
        int base_req = req_cyc;
        for (int i = 0; i < 4; i++) drive(i == 0, 1'b0, addr[8*i +: 8], 0, 32'h11111111);
        checks++; if (mem_addr !== addr) begin errors++; $display("FAIL rd_addr: got %h expected %h", mem_addr, addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b expected 0", mem_we); end
        for (int c = 4; c < 8; c++) begin
            checks++; if (lnk_busy !== 1'b1) begin errors++; $display("FAIL rd_busy c%0d: got %b expected 1", c, lnk_busy); end
            checks++; if (lnk_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_early c%0d: got %b expected 0", c, lnk_oe); end
            drive(0, 0, 8'h33, c == 7, (c == 7) ? rd : 32'h11111111);
        end
        for (int b = 0; b < 4; b++) begin
            checks++; if (lnk_oe !== 1'b1) begin errors++; $display("FAIL rd_oe b%0d: got %b expected 1", b, lnk_oe); end
            checks++; if (lnk_dout !== rd[8*b +: 8]) begin errors++; $display("FAIL rd_dout b%0d: got %h expected %h", b, lnk_dout, rd[8*b +: 8]); end
            checks++; if (lnk_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_out b%0d: got %b expected 0", b, lnk_busy); end
            drive(0, 0, 8'h44, 0, 32'h22222222);
        end
        checks++; if (lnk_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_end: got %b expected 0", lnk_oe); end
        checks++; if (req_cyc - base_req !== 4) begin errors++; $display("FAIL rd_req_cycles: got %0d expected 4", req_cyc - base_req); end
    endtask

    task automatic test_abort();
        int base_acc = acc_cnt;
        int base_abort = abort_cnt;
        drive(1, 1, 8'h55, 0, '0);
        checks++; if (err_abort !== 1'b0) begin errors++; $display("FAIL ab_err_c1: got %b expected 0", err_abort); end
        drive(0, 0, 8'h66, 0, '0);
        drive(1, 0, 8'hAA, 0, '0);
        checks++; if (err_abort !== 1'b1) begin errors++; $display("FAIL ab_err_c3: got %b expected 1", err_abort); end
        drive(0, 1, 8'h00, 0, '0);
        checks++; if (err_abort !== 1'b0) begin errors++; $display("FAIL ab_err_c4: got %b expected 0", err_abort); end
        drive(0, 1, 8'h00, 0, '0);
        drive(0, 0, 8'h00, 0, '0);
        // cycle 6: MEM for the restarted read
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ab_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h000000AA) begin errors++; $display("FAIL ab_addr: got %h expected 000000aa", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ab_we: got %b expected 0", mem_we); end
        drive(0, 0, 8'h00, 1, 32'h04030201);
        checks++; if (lnk_dout !== 8'h01) begin errors++; $display("FAIL ab_dout0: got %h expected 01", lnk_dout); end
        repeat (4) drive(0, 0, 8'h00, 0, '0);
        checks++; if (lnk_oe !== 1'b0) begin errors++; $display("FAIL ab_oe_end: got %b expected 0", lnk_oe); end
        checks++; if (acc_cnt - base_acc !== 1) begin errors++; $display("FAIL ab_acc_cnt: got %0d expected 1", acc_cnt - base_acc); end
        checks++; if (acc_addr !== 32'h000000AA) begin errors++; $display("FAIL ab_acc_addr: got %h expected 000000aa", acc_addr); end
        checks++; if (abort_cnt - base_abort !== 1) begin errors++; $display("FAIL ab_pulses: got %0d expected 1", abort_cnt - base_abort); end
    endtask

    task automatic test_sync_in_mem();
        int base_acc = acc_cnt;
        int base_abort = abort_cnt;
        logic [63:0] frame = {32'h0BADF00D, 32'h00000100};
        for (int i = 0; i < 8; i++) drive(i == 0, 1'b1, frame[8*i +: 8], 0, '0);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sm_req: got %b expected 1", mem_req); end
        drive(0, 0, 8'h00, 0, '0);
        drive(1, 0, 8'h77, 0, '0);
        checks++; if (mem_addr !== 32'h00000100) begin errors++; $display("FAIL sm_addr_hold: got %h expected 00000100", mem_addr); end
        checks++; if (err_abort !== 1'b0) begin errors++; $display("FAIL sm_err: got %b expected 0", err_abort); end
        repeat (3) drive(0, 0, 8'h00, 0, '0);
        // cycle 13: still waiting, ack now
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sm_req_wait: got %b expected 1", mem_req); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sm_we_hold: got %b expected 1", mem_we); end
        drive(0, 0, 8'h00, 1, '0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sm_req_drop: got %b expected 0", mem_req); end
        checks++; if (acc_cnt - base_acc !== 1) begin errors++; $display("FAIL sm_acc_cnt: got %0d expected 1", acc_cnt - base_acc); end
        checks++; if (acc_wdata !== 32'h0BADF00D) begin errors++; $display("FAIL sm_acc_wdata: got %h expected 0badf00d", acc_wdata); end
        checks++; if (acc_we !== 1'b1) begin errors++; $display("FAIL sm_acc_we: got %b expected 1", acc_we); end
        checks++; if (abort_cnt - base_abort !== 0) begin errors++; $display("FAIL sm_pulses: got %0d expected 0", abort_cnt - base_abort); end
    endtask

    task automatic test_reset_mid_mem();
        int base_acc = acc_cnt;
        logic [31:0] addr = 32'h00000020;
        for (int i = 0; i < 4; i++) drive(i == 0, 1'b0, addr[8*i +: 8], 0, '0);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_req: got %b expected 1", mem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_req_async: got %b expected 0", mem_req); end
        checks++; if (lnk_busy !== 1'b0) begin errors++; $display("FAIL rm_busy_async: got %b expected 0", lnk_busy); end
        checks++; if (lnk_oe !== 1'b0) begin errors++; $display("FAIL rm_oe_async: got %b expected 0", lnk_oe); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr_async: got %h expected 0", mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 8'h00, 0, '0);
        checks++; if (acc_cnt - base_acc !== 0) begin errors++; $display("FAIL rm_acc_cnt: got %0d expected 0", acc_cnt - base_acc); end
        test_write(32'hA5A50001, 32'h13579BDF, "rm_wr");
    endtask

    initial begin
        test_reset();
        test_write(32'h12345678, 32'hDEADBEEF, "wr");
        test_read();
        test_abort();
        test_sync_in_mem();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
